main: RTL and testbench
=======================

# main

Two-road traffic-light controller (main road / side road) for the board top level. Sequences the green/yellow/red phases with per-second countdowns and accepts car sensors, pedestrian requests, peak-hour timing, flash, police and emergency overrides. Drives two RGB LEDs, an 8-digit multiplexed seven-segment display, and exposes the countdowns and phase code for debug.

## Interface
- TICK_DIV, 100_000_000: clocks per one-second tick.
- SCAN_DIV, 100_000: clocks per display digit slot.
- clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Set  in  1  system enable; 0 = standby.
- Online  in  1  flash (maintenance) mode.
- Police  in  1  police override: all red.
- AV  in  1  emergency-vehicle override: main green, side red.
- Peaks  in  1  peak-hour timing select.
- CarRatio  in  2  peak timing profile.
- Ten  in  1  clamp current green remaining time to ≤10 s.
- Cm / Cc  in  1  car present on main / side road.
- PQm / PQc  in  1  pedestrian waiting to cross main / side road.
- Source  out  1  siren indicator.
- LED16 / LED17  out  3  main / side light, {R,G,B}.
- SIG_C  out  8  segment cathodes, active-low, bit0=CA…bit6=CG, bit7=DP.
- AN  out  8  digit anodes, active-low.
- main_rest_time / sub_rest_time  out  7  seconds until that road's light changes.
- control_state  out  4  phase code.

## Operation
- Phase codes: 0 OFF, 1 MAIN_GREEN, 2 MAIN_YELLOW, 3 SIDE_GREEN, 4 SIDE_YELLOW, 5 FLASH, 6 POLICE, 7 EMERGENCY.
- Priority, evaluated every clock: Set=0 → OFF; else Police → POLICE; else AV → EMERGENCY; else Online → FLASH; else normal cycle 1→2→3→4→1.
- Leaving any of phases 0, 5, 6, 7 enters MAIN_GREEN at full duration with the tick counter cleared.
- Light colours:
  - red=100, green=010, yellow=110, off=000.
  - Phase 1: main green, side red. Phase 2: main yellow, side red.
  - Phase 3: main red, side green. Phase 4: main red, side yellow.
  - OFF: both off. POLICE: both red. EMERGENCY: main green, side red.
  - FLASH: both yellow while the second counter is even, off while odd.
- Durations (s):
  - Yellow = 3.
  - Normal (Peaks=0): main 30, side 20.
  - Peaks=1: CarRatio 0 → 45/30; 1 → 60/20; 2 → 30/60; 3 → same as 0.
  - Latched on phase entry; input changes apply at next entry.
- Countdown: a phase of N s loads rest=N and decrements on each tick. At a tick with rest=1 it advances.
- Phase 1: main_rest=rest, sub_rest=rest+3. Phase 3: sub_rest=rest, main_rest=rest+3. Phases 2/4: both=rest. Phases 0, 5, 6, 7: both 0.
- Car sensing:
  - End of MAIN_GREEN with Cc=0: stay in MAIN_GREEN and reload.
  - End of SIDE_GREEN with Cm=0 and Cc=1: stay in SIDE_GREEN and reload.
- Green clamps (phase 1 or 3 only), applied each clock while asserted:
  - PQm in phase 1, or PQc in phase 3: rest=min(rest,5).
  - Ten: rest=min(rest,10).
- Source=1 in POLICE or EMERGENCY, else 0.
- Display:
  - Digits 7/6: main_rest tens/units. Digits 1/0: sub_rest tens/units. Other digits blank (AN bit 1).
  - One digit active per SCAN_DIV clocks, scanning 0→7.
  - DP always off. In OFF, all anodes are 1.

## Timing
- Reset:
  - control_state=0, both LEDs 000, rest times 0, Source 0, AN=8'hFF, SIG_C=8'hFF.
  - Tick and scan counters are 0.
- If Set=1 when Reset releases, phase 1 is entered on the first clock edge.
- Override entry/exit takes effect on the clock edge after the input changes. No tick alignment.
- All outputs are registered; one clock latency from state to LEDs/segments.
- Rest times never exceed 99 and never underflow below 1 in timed phases.

## Configuration
- SEG_DISPLAY_EN defined: the scan multiplexer and decoder are built.
- SEG_DISPLAY_EN undefined: AN=8'hFF and SIG_C=8'hFF constantly; all other behaviour is unchanged.

## Test plan
- TICK_DIV=10, Set=1, Cc=Cm=1, Peaks=0 → state 1 for 300 clk (main_rest 30→1, sub_rest 33→4), then 2 for 30, 3 for 200, 4 for 30, back to 1.
- Peaks=1, CarRatio=1, applied mid-phase-1 → next main green 60 s, side green 20 s.
- Cc=0 → MAIN_GREEN repeats with reload, state never 2. Restore Cc=1 → normal cycle resumes at next green end.
- PQm=1 in phase 1 with rest 25 → rest becomes 5 next clock. Ten=1 with rest 25 → rest becomes 10.
- Police=1 → state 6, LEDs 100/100, Source=1. Add AV=1 → still 6. Drop Police → state 7, LED16=010. Drop AV → state 1, full duration.
- Online=1 → state 5, LEDs toggle 110/000 each tick. Reset asserted mid-cycle → all outputs at reset values immediately.

Source files
------------

// File: rtl/main_if.sv
// Board-level signal bundle for the traffic-light controller: road/override inputs,
// lights, seven-segment display and debug countdowns.
interface main_if;
  logic       Set;
  logic       Online;
  logic       Police;
  logic       AV;
  logic       Peaks;
  logic [1:0] CarRatio;
  logic       Ten;
  logic       Cm;
  logic       Cc;
  logic       PQm;
  logic       PQc;
  logic       Source;
  logic [2:0] LED16;
  logic [2:0] LED17;
  logic [7:0] SIG_C;
  logic [7:0] AN;
  logic [6:0] main_rest_time;
  logic [6:0] sub_rest_time;
  logic [3:0] control_state;

  modport slave (
    input  Set, Online, Police, AV, Peaks, CarRatio, Ten, Cm, Cc, PQm, PQc,
    output Source, LED16, LED17, SIG_C, AN, main_rest_time, sub_rest_time, control_state
  );

  modport master (
    output Set, Online, Police, AV, Peaks, CarRatio, Ten, Cm, Cc, PQm, PQc,
    input  Source, LED16, LED17, SIG_C, AN, main_rest_time, sub_rest_time, control_state
  );
endinterface

// File: rtl/main.sv
// Two-road traffic-light controller with overrides, countdowns and a multiplexed
// 8-digit display. Define SEG_DISPLAY_EN to build the scan multiplexer and decoder.
module main #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic  clk,
  input  logic  Reset,
  main_if.slave bus
);

  typedef enum logic [3:0] {
    S_OFF    = 4'd0,
    S_MG     = 4'd1,
    S_MY     = 4'd2,
    S_SG     = 4'd3,
    S_SY     = 4'd4,
    S_FLASH  = 4'd5,
    S_POLICE = 4'd6,
    S_EMERG  = 4'd7
  } phase_t;

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [6:0] YELLOW_S = 7'd3;

  localparam logic [2:0] C_RED = 3'b100;
  localparam logic [2:0] C_GRN = 3'b010;
  localparam logic [2:0] C_YEL = 3'b110;
  localparam logic [2:0] C_OFF = 3'b000;

  phase_t       state, state_n;
  logic [6:0]   rest, rest_n, clamped;
  logic [6:0]   main_dur, side_dur;
  logic [6:0]   main_rest_c, sub_rest_c;
  logic [TW-1:0] tick_cnt;
  logic         tick, tick_clr, parity;

  assign tick = (tick_cnt == TICK_LAST);

  always_comb begin
    main_dur = 7'd30;
    side_dur = 7'd20;
    if (bus.Peaks) begin
      case (bus.CarRatio)
        2'd1:    begin main_dur = 7'd60; side_dur = 7'd20; end
        2'd2:    begin main_dur = 7'd30; side_dur = 7'd60; end
        default: begin main_dur = 7'd45; side_dur = 7'd30; end
      endcase
    end
  end

  always_comb begin
    clamped = rest;
    if (((state == S_MG) && bus.PQm) || ((state == S_SG) && bus.PQc)) begin
      if (clamped > 7'd5) clamped = 7'd5;
    end
    if (((state == S_MG) || (state == S_SG)) && bus.Ten) begin
      if (clamped > 7'd10) clamped = 7'd10;
    end
  end

  always_comb begin
    state_n  = state;
    rest_n   = rest;
    tick_clr = 1'b0;
    if (!bus.Set) begin
      state_n = S_OFF;
      rest_n  = '0;
    end else if (bus.Police) begin
      state_n = S_POLICE;
      rest_n  = '0;
    end else if (bus.AV) begin
      state_n = S_EMERG;
      rest_n  = '0;
    end else if (bus.Online) begin
      state_n = S_FLASH;
      rest_n  = '0;
    end else begin
      case (state)
        S_MG, S_MY, S_SG, S_SY: begin
          rest_n = clamped;
          if (tick) begin
            if (clamped != 7'd1) begin
              rest_n = clamped - 7'd1;
            end else begin
              // Expiry: a road with no competing traffic keeps its green.
              case (state)
                S_MG: begin
                  if (bus.Cc) begin
                    state_n = S_MY;
                    rest_n  = YELLOW_S;
                  end else begin
                    rest_n = main_dur;
                  end
                end
                S_MY: begin
                  state_n = S_SG;
                  rest_n  = side_dur;
                end
                S_SG: begin
                  if (!bus.Cm && bus.Cc) begin
                    rest_n = side_dur;
                  end else begin
                    state_n = S_SY;
                    rest_n  = YELLOW_S;
                  end
                end
                default: begin
                  state_n = S_MG;
                  rest_n  = main_dur;
                end
              endcase
            end
          end
        end
        default: begin
          state_n  = S_MG;
          rest_n   = main_dur;
          tick_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_OFF;
      rest     <= '0;
      tick_cnt <= '0;
      parity   <= 1'b0;
    end else begin
      state <= state_n;
      rest  <= rest_n;
      if (tick || tick_clr) tick_cnt <= '0;
      else                  tick_cnt <= tick_cnt + 1'b1;
      if (tick) parity <= ~parity;
    end
  end

  always_comb begin
    main_rest_c = '0;
    sub_rest_c  = '0;
    case (state)
      S_MG:       begin main_rest_c = rest;            sub_rest_c = rest + YELLOW_S; end
      S_SG:       begin main_rest_c = rest + YELLOW_S; sub_rest_c = rest;            end
      S_MY, S_SY: begin main_rest_c = rest;            sub_rest_c = rest;            end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      bus.control_state  <= '0;
      bus.LED16          <= C_OFF;
      bus.LED17          <= C_OFF;
      bus.main_rest_time <= '0;
      bus.sub_rest_time  <= '0;
      bus.Source         <= 1'b0;
    end else begin
      bus.control_state  <= state;
      bus.main_rest_time <= main_rest_c;
      bus.sub_rest_time  <= sub_rest_c;
      bus.Source         <= (state == S_POLICE) || (state == S_EMERG);
      case (state)
        S_MG:     begin bus.LED16 <= C_GRN; bus.LED17 <= C_RED; end
        S_MY:     begin bus.LED16 <= C_YEL; bus.LED17 <= C_RED; end
        S_SG:     begin bus.LED16 <= C_RED; bus.LED17 <= C_GRN; end
        S_SY:     begin bus.LED16 <= C_RED; bus.LED17 <= C_YEL; end
        S_FLASH:  begin
          bus.LED16 <= parity ? C_OFF : C_YEL;
          bus.LED17 <= parity ? C_OFF : C_YEL;
        end
        S_POLICE: begin bus.LED16 <= C_RED; bus.LED17 <= C_RED; end
        S_EMERG:  begin bus.LED16 <= C_GRN; bus.LED17 <= C_RED; end
        default:  begin bus.LED16 <= C_OFF; bus.LED17 <= C_OFF; end
      endcase
    end
  end

`ifdef SEG_DISPLAY_EN
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [SW-1:0] scan_cnt;
  logic [2:0]    digit;
  logic [6:0]    dval;
  logic          blank;

  function automatic logic [6:0] seg7(input logic [6:0] v);
    case (v)
      7'd0:    return 7'h3F;
      7'd1:    return 7'h06;
      7'd2:    return 7'h5B;
      7'd3:    return 7'h4F;
      7'd4:    return 7'h66;
      7'd5:    return 7'h6D;
      7'd6:    return 7'h7D;
      7'd7:    return 7'h07;
      7'd8:    return 7'h7F;
      7'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  always_comb begin
    blank = 1'b1;
    dval  = '0;
    case (digit)
      3'd7:    begin dval = main_rest_c / 7'd10; blank = 1'b0; end
      3'd6:    begin dval = main_rest_c % 7'd10; blank = 1'b0; end
      3'd1:    begin dval = sub_rest_c / 7'd10;  blank = 1'b0; end
      3'd0:    begin dval = sub_rest_c % 7'd10;  blank = 1'b0; end
      default: ;
    endcase
    if (state == S_OFF) blank = 1'b1;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      scan_cnt  <= '0;
      digit     <= '0;
      bus.AN    <= '1;
      bus.SIG_C <= '1;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        digit    <= digit + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      bus.AN    <= blank ? 8'hFF : ~(8'h01 << digit);
      bus.SIG_C <= blank ? 8'hFF : {1'b1, ~seg7(dval)};
    end
  end
`else
  assign bus.AN    = '1;
  assign bus.SIG_C = '1;
`endif

endmodule

// File: tb/tb_main.sv
// Randomised scoreboard bench for the traffic-light controller against a
// phase/second-level reference model.
module tb_main;
  localparam int TD = 10;
  localparam int SD = 3;

  logic clk = 1'b0;
  logic rst;

  main_if bus();

  main #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cs;
    logic [2:0] l16;
    logic [2:0] l17;
    logic [6:0] mr;
    logic [6:0] sr;
    logic       src;
    logic [7:0] an;
    logic [7:0] sg;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total  = 0;

  // Reference model: phase code, seconds remaining, clocks into current second,
  // second parity, display slot position.
  int m_ph, m_rest, m_tc, m_sc, m_dig;
  bit m_par;

`ifdef SEG_DISPLAY_EN
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`endif

  localparam logic [2:0] R = 3'b100, G = 3'b010, Y = 3'b110, O = 3'b000;

  function automatic exp_t reset_exp();
    exp_t e;
    e.cs = 0; e.l16 = O; e.l17 = O; e.mr = 0; e.sr = 0; e.src = 0;
    e.an = 8'hFF; e.sg = 8'hFF;
    return e;
  endfunction

  function automatic int gdur(bit main_road);
    if (!bus.Peaks) return main_road ? 30 : 20;
    case (bus.CarRatio)
      2'd1:    return main_road ? 60 : 20;
      2'd2:    return main_road ? 30 : 60;
      default: return main_road ? 45 : 30;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int mr, sr;
    mr = 0; sr = 0;
    if (m_ph == 1) begin mr = m_rest; sr = m_rest + 3; end
    if (m_ph == 3) begin mr = m_rest + 3; sr = m_rest; end
    if (m_ph == 2 || m_ph == 4) begin mr = m_rest; sr = m_rest; end
    e.mr  = 7'(mr);
    e.sr  = 7'(sr);
    e.cs  = 4'(m_ph);
    e.src = (m_ph == 6 || m_ph == 7);
    case (m_ph)
      1: begin e.l16 = G; e.l17 = R; end
      2: begin e.l16 = Y; e.l17 = R; end
      3: begin e.l16 = R; e.l17 = G; end
      4: begin e.l16 = R; e.l17 = Y; end
      5: begin e.l16 = m_par ? O : Y; e.l17 = m_par ? O : Y; end
      6: begin e.l16 = R; e.l17 = R; end
      7: begin e.l16 = G; e.l17 = R; end
      default: begin e.l16 = O; e.l17 = O; end
    endcase
    e.an = 8'hFF;
    e.sg = 8'hFF;
`ifdef SEG_DISPLAY_EN
    begin
      int v;
      bit blank;
      blank = (m_ph == 0);
      v = 0;
      case (m_dig)
        7: v = mr / 10;
        6: v = mr % 10;
        1: v = sr / 10;
        0: v = sr % 10;
        default: blank = 1;
      endcase
      if (!blank) begin
        e.an = ~(8'h01 << m_dig);
        e.sg = {1'b1, ~segtab[v]};
      end
    end
`endif
    return e;
  endfunction

  task automatic model_step();
    bit tick;
    int ntc, r;
    tick = (m_tc == TD - 1);
    ntc  = tick ? 0 : m_tc + 1;
    if (m_sc == SD - 1) begin m_sc = 0; m_dig = (m_dig + 1) % 8; end
    else m_sc++;
    if (tick) m_par = ~m_par;
    if (!bus.Set)          begin m_ph = 0; m_rest = 0; end
    else if (bus.Police)   begin m_ph = 6; m_rest = 0; end
    else if (bus.AV)       begin m_ph = 7; m_rest = 0; end
    else if (bus.Online)   begin m_ph = 5; m_rest = 0; end
    else if (m_ph == 0 || m_ph >= 5) begin
      m_ph = 1; m_rest = gdur(1); ntc = 0;
    end else begin
      r = m_rest;
      if ((m_ph == 1 && bus.PQm) || (m_ph == 3 && bus.PQc)) r = (r > 5) ? 5 : r;
      if ((m_ph == 1 || m_ph == 3) && bus.Ten) r = (r > 10) ? 10 : r;
      if (tick) begin
        if (r > 1) r = r - 1;
        else begin
          case (m_ph)
            1: if (bus.Cc) begin m_ph = 2; r = 3; end else r = gdur(1);
            2: begin m_ph = 3; r = gdur(0); end
            3: if (!bus.Cm && bus.Cc) r = gdur(0); else begin m_ph = 4; r = 3; end
            default: begin m_ph = 1; r = gdur(1); end
          endcase
        end
      end
      m_rest = r;
    end
    m_tc = ntc;
  endtask

  task automatic push_model();
    if (rst) begin
      q.push_back(reset_exp());
      m_ph = 0; m_rest = 0; m_tc = 0; m_sc = 0; m_dig = 0; m_par = 0;
    end else begin
      q.push_back(model_out());
      model_step();
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
  endtask

  task automatic compare_all(exp_t e);
    check("control_state", 32'(bus.control_state), 32'(e.cs));
    check("LED16", 32'(bus.LED16), 32'(e.l16));
    check("LED17", 32'(bus.LED17), 32'(e.l17));
    check("main_rest_time", 32'(bus.main_rest_time), 32'(e.mr));
    check("sub_rest_time", 32'(bus.sub_rest_time), 32'(e.sr));
    check("Source", 32'(bus.Source), 32'(e.src));
    check("AN", 32'(bus.AN), 32'(e.an));
    check("SIG_C", 32'(bus.SIG_C), 32'(e.sg));
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) compare_all(q.pop_front());
  end

  task automatic mutate();
    int idx;
    if ($urandom_range(0, 39) != 0) return;
    idx = $urandom_range(0, 10);
    if (idx <= 3 && $urandom_range(0, 2) != 0) return;
    case (idx)
      0: bus.Set = ($urandom_range(0, 3) != 0);
      1: bus.Police = ~bus.Police;
      2: bus.AV = ~bus.AV;
      3: bus.Online = ~bus.Online;
      4: bus.Peaks = ~bus.Peaks;
      5: bus.CarRatio = 2'($urandom_range(0, 3));
      6: bus.Ten = ~bus.Ten;
      7: bus.Cm = ~bus.Cm;
      8: bus.Cc = ~bus.Cc;
      9: bus.PQm = ~bus.PQm;
      default: bus.PQc = ~bus.PQc;
    endcase
  endtask

  task automatic run(int n, bit rnd = 0);
    repeat (n) begin
      if (rnd) mutate();
      push_model();
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.Set = 1; bus.Online = 0; bus.Police = 0; bus.AV = 0; bus.Peaks = 0;
    bus.CarRatio = 0; bus.Ten = 0; bus.Cm = 1; bus.Cc = 1; bus.PQm = 0; bus.PQc = 0;
    @(negedge clk);
    run(3);
    rst = 1'b0;
    run(600);
    run(150);
    bus.Peaks = 1; bus.CarRatio = 1;
    run(1500);
    bus.Peaks = 0;
    run(80);
    bus.PQm = 1; run(4); bus.PQm = 0;
    run(400);
    bus.Ten = 1; run(4); bus.Ten = 0;
    run(300);
    bus.PQc = 1; run(4); bus.PQc = 0;
    run(200);
    bus.Cc = 0; run(1000);
    bus.Cc = 1; run(800);
    bus.Cm = 0; run(900);
    bus.Cm = 1; run(300);
    bus.Police = 1; run(20);
    bus.AV = 1; run(20);
    bus.Police = 0; run(20);
    bus.AV = 0; run(50);
    bus.Online = 1; run(60);
    bus.Online = 0; run(30);
    bus.Set = 0; run(20);
    bus.Set = 1; run(130);
    rst = 1'b1;
    #1;
    compare_all(reset_exp());
    run(3);
    rst = 1'b0;
    run(100);
    run(3000, 1);
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
